l2_bank_arbiter: RTL

Per-bank two-requester arbiter placed between two word-addressed memory requesters (ports A and B) and the N_BANKS parallel SRAM column interfaces of the L2 memory array. Each bank is granted to at most one port per cycle, with round-robin fairness on conflict. Read data is returned to the owning port after a fixed memory latency. An optional zero-initialisation sweep runs after reset.

---
 rtl/l2_mem_pkg.sv | 31 +++
 rtl/l2_bank_rr_arb.sv | 72 +++++++
 rtl/l2_bank_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/l2_mem_pkg.sv
// l2_mem_pkg: shared types for the L2 memory array slice (bank request
// payload, port identifiers and arbiter states).
package l2_mem_pkg;

    localparam int unsigned L2_ADDR_W = 14;
    localparam int unsigned L2_DATA_W = 64;
    localparam int unsigned L2_BE_W   = L2_DATA_W / 8;

    typedef logic [L2_ADDR_W-1:0] l2_addr_t;
    typedef logic [L2_DATA_W-1:0] l2_data_t;
    typedef logic [L2_BE_W-1:0]   l2_be_t;

    // One bank access as seen on the SRAM column interface.
    typedef struct packed {
        l2_addr_t addr;
        logic     wen;
        l2_data_t wdata;
        l2_be_t   be;
    } bank_req_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/l2_bank_rr_arb.sv
// l2_bank_rr_arb: two-requester round-robin grant for a single bank, plus
// the read-return shift register that remembers which port owns each
// in-flight read.
module l2_bank_rr_arb
    import l2_mem_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic a_req_i,
    input  logic b_req_i,
    input  logic a_wen_i,
    input  logic b_wen_i,
    output logic a_gnt_o,
    output logic b_gnt_o,
    output logic a_rvalid_o,
    output logic b_rvalid_o
);

    logic                   prio_q;
    logic                   conflict;
    logic                   rd_push;
    port_id_e               rd_port;
    logic [MEM_LATENCY-1:0] vld_q;
    port_id_e               port_q [MEM_LATENCY];

    // Grant the lone requester, or the prioritised one when both ask.
    always_comb begin
        a_gnt_o  = 1'b0;
        b_gnt_o  = 1'b0;
        conflict = 1'b0;
        if (en_i) begin
            conflict = a_req_i & b_req_i;
            a_gnt_o  = a_req_i & (~b_req_i | ~prio_q);
            b_gnt_o  = b_req_i & (~a_req_i | prio_q);
        end
        rd_push = (a_gnt_o & ~a_wen_i) | (b_gnt_o & ~b_wen_i);
        rd_port = b_gnt_o ? PORT_B : PORT_A;
    end

    // Priority passes to the loser, and only when there was a conflict.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else if (conflict) begin
            prio_q <= ~prio_q;
        end
    end

    // Shift {valid, port} along with the memory latency; writes push bubbles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                port_q[i] <= PORT_A;
            end
        end else begin
            vld_q[0]  <= rd_push;
            port_q[0] <= rd_port;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                port_q[i] <= port_q[i-1];
            end
        end
    end

    assign a_rvalid_o = vld_q[MEM_LATENCY-1] & (port_q[MEM_LATENCY-1] == PORT_A);
    assign b_rvalid_o = vld_q[MEM_LATENCY-1] & (port_q[MEM_LATENCY-1] == PORT_B);

endmodule

// File: rtl/l2_bank_arbiter.sv
// l2_bank_arbiter: per-bank two-port arbiter in front of the L2 SRAM banks.
// Optional feature macro: L2_BANK_ARB_INIT_EN adds a post-reset sweep that
// writes zero to every word of every bank before traffic is accepted.
module l2_bank_arbiter
    import l2_mem_pkg::*;
#(
    parameter int unsigned N_BANKS     = 4,
    parameter int unsigned ADDR_W      = L2_ADDR_W,
    parameter int unsigned DATA_W      = L2_DATA_W,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_BANKS-1:0]            a_req_i,
    output logic [N_BANKS-1:0]            a_gnt_o,
    input  logic [N_BANKS*ADDR_W-1:0]     a_addr_i,
    input  logic [N_BANKS-1:0]            a_wen_i,
    input  logic [N_BANKS*DATA_W-1:0]     a_wdata_i,
    input  logic [N_BANKS*DATA_W/8-1:0]   a_be_i,
    output logic [N_BANKS-1:0]            a_rvalid_o,
    output logic [N_BANKS*DATA_W-1:0]     a_rdata_o,
    input  logic [N_BANKS-1:0]            b_req_i,
    output logic [N_BANKS-1:0]            b_gnt_o,
    input  logic [N_BANKS*ADDR_W-1:0]     b_addr_i,
    input  logic [N_BANKS-1:0]            b_wen_i,
    input  logic [N_BANKS*DATA_W-1:0]     b_wdata_i,
    input  logic [N_BANKS*DATA_W/8-1:0]   b_be_i,
    output logic [N_BANKS-1:0]            b_rvalid_o,
    output logic [N_BANKS*DATA_W-1:0]     b_rdata_o,
    output logic [N_BANKS-1:0]            mem_req_o,
    output logic [N_BANKS*ADDR_W-1:0]     mem_addr_o,
    output logic [N_BANKS-1:0]            mem_wen_o,
    output logic [N_BANKS*DATA_W-1:0]     mem_wdata_o,
    output logic [N_BANKS*DATA_W/8-1:0]   mem_be_o,
    input  logic [N_BANKS*DATA_W-1:0]     mem_rdata_i,
    output logic                          init_done_o
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic              run;
    logic              sweep;
    logic [ADDR_W-1:0] sweep_addr;
    bank_req_t         a_bank   [N_BANKS];
    bank_req_t         b_bank   [N_BANKS];
    bank_req_t         mem_bank [N_BANKS];

`ifdef L2_BANK_ARB_INIT_EN
    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;

    // State register and sweep counter; reset restarts the sweep at word 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Sweep every word once, then stay in RUN until the next reset.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        run        = 1'b0;
        case (state_q)
            INIT: begin
                if (init_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            RUN: begin
                run = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign sweep       = ~run;
    assign sweep_addr  = init_cnt_q;
    assign init_done_o = run;
`else
    assign run         = 1'b1;
    assign sweep       = 1'b0;
    assign sweep_addr  = '0;
    assign init_done_o = 1'b1;
`endif

    for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
        l2_bank_rr_arb #(
            .MEM_LATENCY (MEM_LATENCY)
        ) u_arb (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .en_i       (run),
            .a_req_i    (a_req_i[g]),
            .b_req_i    (b_req_i[g]),
            .a_wen_i    (a_wen_i[g]),
            .b_wen_i    (b_wen_i[g]),
            .a_gnt_o    (a_gnt_o[g]),
            .b_gnt_o    (b_gnt_o[g]),
            .a_rvalid_o (a_rvalid_o[g]),
            .b_rvalid_o (b_rvalid_o[g])
        );
    end

    // Route the granted port (port A when idle) or the zero sweep to each bank.
    always_comb begin
        mem_req_o   = '0;
        mem_addr_o  = '0;
        mem_wen_o   = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        for (int i = 0; i < N_BANKS; i++) begin
            a_bank[i] = '{addr:  a_addr_i[i*ADDR_W +: ADDR_W],
                          wen:   a_wen_i[i],
                          wdata: a_wdata_i[i*DATA_W +: DATA_W],
                          be:    a_be_i[i*BE_W +: BE_W]};
            b_bank[i] = '{addr:  b_addr_i[i*ADDR_W +: ADDR_W],
                          wen:   b_wen_i[i],
                          wdata: b_wdata_i[i*DATA_W +: DATA_W],
                          be:    b_be_i[i*BE_W +: BE_W]};
            mem_bank[i] = b_gnt_o[i] ? b_bank[i] : a_bank[i];
            if (sweep) begin
                mem_bank[i] = '{addr: sweep_addr, wen: 1'b1, wdata: '0, be: '1};
            end
            mem_req_o[i]                     = sweep | a_gnt_o[i] | b_gnt_o[i];
            mem_addr_o[i*ADDR_W +: ADDR_W]   = mem_bank[i].addr;
            mem_wen_o[i]                     = mem_bank[i].wen;
            mem_wdata_o[i*DATA_W +: DATA_W]  = mem_bank[i].wdata;
            mem_be_o[i*BE_W +: BE_W]         = mem_bank[i].be;
        end
    end

    assign a_rdata_o = mem_rdata_i;
    assign b_rdata_o = mem_rdata_i;

endmodule
